// File: rtl/adau1761_reg_arbiter_if.sv
// adau1761_reg_arbiter_if: requester and configurator signals of the ADAU1761 register arbiter
interface adau1761_reg_arbiter_if #(
   parameter int N_REQ = 4
);
   logic                 init_req;
   logic                 init_ack;
   logic [N_REQ-1:0]     req_valid;
   logic [N_REQ-1:0]     req_rnw;
   logic [16*N_REQ-1:0]  req_addr;
   logic [8*N_REQ-1:0]   req_wdata;
   logic [N_REQ-1:0]     req_ack;
   logic [7:0]           rsp_rdata;
   logic                 rsp_err;
   logic                 cfg_write;
   logic                 cfg_read;
   logic                 cfg_init;
   logic [15:0]          cfg_address;
   logic [7:0]           cfg_wdata;
   logic [7:0]           cfg_rdata;
   logic                 cfg_done;

   modport slave (
      input  init_req, req_valid, req_rnw, req_addr, req_wdata, cfg_rdata, cfg_done,
      output init_ack, req_ack, rsp_rdata, rsp_err, cfg_write, cfg_read, cfg_init, cfg_address, cfg_wdata
   );

   modport master (
      output init_req, req_valid, req_rnw, req_addr, req_wdata, cfg_rdata, cfg_done,
      input  init_ack, req_ack, rsp_rdata, rsp_err, cfg_write, cfg_read, cfg_init, cfg_address, cfg_wdata
   );
endinterface

// File: rtl/adau1761_reg_arbiter.sv
// adau1761_reg_arbiter: round-robin sharing of the ADAU1761 SPI register engine; define ADAU_ARB_TIMEOUT_EN for the WAIT watchdog
module adau1761_reg_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   resetn,
   adau1761_reg_arbiter_if.slave  bus
);
   localparam int IW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t          state, state_nx;
   logic [IW-1:0]   grant, last_grant, sel;
   logic            is_init, rnw, to_hit;

   // first pending requester searching upward from last_grant+1 with wrap
   always_comb begin
      sel = last_grant;
      for (int k = N_REQ; k >= 1; k--)
         if (bus.req_valid[(int'(last_grant) + k) % N_REQ]) sel = IW'((int'(last_grant) + k) % N_REQ);
   end

   // state register
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) state <= IDLE;
      else state <= state_nx;

   // next state
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  state_nx = (bus.init_req || |bus.req_valid) ? ISSUE : IDLE;
         ISSUE: state_nx = WAIT;
         WAIT:  state_nx = (bus.cfg_done || to_hit) ? RESP : WAIT;
         RESP:  state_nx = IDLE;
      endcase
   end

   assign bus.cfg_init  = state == ISSUE && is_init;
   assign bus.cfg_read  = state == ISSUE && !is_init && rnw;
   assign bus.cfg_write = state == ISSUE && !is_init && !rnw;
   assign bus.init_ack  = state == RESP && is_init;
   assign bus.req_ack   = (state == RESP && !is_init) ? N_REQ'(1) << grant : '0;

   // grant latch, read-data capture and round-robin pointer
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         grant           <= '0;
         last_grant      <= IW'(N_REQ - 1);
         is_init         <= 1'b0;
         rnw             <= 1'b0;
         bus.cfg_address <= 16'h0000;
         bus.cfg_wdata   <= 8'h00;
         bus.rsp_rdata   <= 8'h00;
      end else begin
         unique case (state)
            IDLE:
               if (bus.init_req) begin
                  is_init         <= 1'b1;
                  rnw             <= 1'b0;
                  bus.cfg_address <= 16'h0000;
                  bus.cfg_wdata   <= 8'h00;
               end else if (|bus.req_valid) begin
                  is_init         <= 1'b0;
                  grant           <= sel;
                  rnw             <= bus.req_rnw[sel];
                  bus.cfg_address <= bus.req_addr[16*int'(sel) +: 16];
                  bus.cfg_wdata   <= bus.req_wdata[8*int'(sel) +: 8];
               end
            WAIT:
               if (bus.cfg_done) bus.rsp_rdata <= (rnw && !is_init) ? bus.cfg_rdata : 8'h00;
               else if (to_hit) bus.rsp_rdata <= 8'h00;
            RESP:
               if (!is_init) last_grant <= grant;
            default: ;
         endcase
      end

`ifdef ADAU_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [TW-1:0] cnt;

   assign to_hit = state == WAIT && !bus.cfg_done && cnt == TW'(TIMEOUT - 1);

   // watchdog counts WAIT cycles; error flag reflects how WAIT ended
   always_ff @(posedge clk or negedge resetn)
      if (!resetn) begin
         cnt         <= '0;
         bus.rsp_err <= 1'b0;
      end else begin
         cnt <= (state == WAIT) ? cnt + 1'b1 : '0;
         if (state == WAIT && (bus.cfg_done || to_hit)) bus.rsp_err <= to_hit;
      end
`else
   assign to_hit      = 1'b0;
   assign bus.rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_adau1761_reg_arbiter.sv
// tb_adau1761_reg_arbiter: directed tests of the ADAU1761 register arbiter
module tb_adau1761_reg_arbiter;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   adau1761_reg_arbiter_if #(.N_REQ(4)) bus ();

   adau1761_reg_arbiter #(.N_REQ(4), .TIMEOUT(16)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cmd(output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!(bus.cfg_write || bus.cfg_read || bus.cfg_init) && cyc < 64);
   endtask

   task automatic do_reset();
      resetn        = 1'b0;
      bus.init_req  = 1'b0;
      bus.req_valid = '0;
      bus.req_rnw   = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.cfg_rdata = 8'h00;
      bus.cfg_done  = 1'b0;
      step();
      step();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      resetn        = 1'b0;
      bus.req_valid = 4'b1111;
      step();
      step();
      n_cmp++;
      if ({bus.init_ack, bus.req_ack, bus.cfg_write, bus.cfg_read, bus.cfg_init, bus.cfg_address,
           bus.cfg_wdata, bus.rsp_rdata, bus.rsp_err} !== 41'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got ack=%b init_ack=%b cmd=%b addr=%h wdata=%h rdata=%h err=%b, want all zero",
                  bus.req_ack, bus.init_ack, {bus.cfg_write, bus.cfg_read, bus.cfg_init}, bus.cfg_address,
                  bus.cfg_wdata, bus.rsp_rdata, bus.rsp_err);
      end
      bus.req_valid = '0;
      resetn        = 1'b1;
      step();
   endtask

   task automatic test_single_write();
      int cyc;
      int bad;
      bus.req_rnw          = 4'b0000;
      bus.req_addr[31:16]  = 16'h4019;
      bus.req_wdata[15:8]  = 8'h03;
      bus.cfg_rdata        = 8'hAA;
      bus.req_valid        = 4'b0010;
      wait_cmd(cyc);
      n_cmp++;
      if (cyc !== 1) begin n_err++; $display("FAIL write_latency: got %0d cycles, want 1", cyc); end
      n_cmp++;
      if ({bus.cfg_write, bus.cfg_read, bus.cfg_init, bus.cfg_address, bus.cfg_wdata} !== {3'b100, 16'h4019, 8'h03}) begin
         n_err++;
         $display("FAIL write_cmd: got cmd=%b addr=%h wdata=%h, want cmd=100 addr=4019 wdata=03",
                  {bus.cfg_write, bus.cfg_read, bus.cfg_init}, bus.cfg_address, bus.cfg_wdata);
      end
      bad = 0;
      for (int i = 0; i < 39; i++) begin
         step();
         if ({bus.cfg_write, bus.cfg_read, bus.cfg_init} != 3'b000 || bus.cfg_address != 16'h4019 ||
             bus.cfg_wdata != 8'h03 || bus.req_ack != 4'b0000) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL write_wait_hold: got %0d bad WAIT cycles, want 0", bad); end
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      n_cmp++;
      if ({bus.req_ack, bus.rsp_err, bus.rsp_rdata} !== {4'b0010, 1'b0, 8'h00}) begin
         n_err++;
         $display("FAIL write_ack: got ack=%b err=%b rdata=%h, want ack=0010 err=0 rdata=00",
                  bus.req_ack, bus.rsp_err, bus.rsp_rdata);
      end
      bus.req_valid = '0;
      step();
      n_cmp++;
      if (bus.req_ack !== 4'b0000) begin n_err++; $display("FAIL write_ack_width: got ack=%b, want 0000", bus.req_ack); end
   endtask

   task automatic test_single_read();
      int cyc;
      bus.req_addr[47:32] = 16'h40F9;
      bus.req_rnw         = 4'b0100;
      bus.req_valid       = 4'b0100;
      wait_cmd(cyc);
      n_cmp++;
      if ({cyc == 1, bus.cfg_write, bus.cfg_read, bus.cfg_init, bus.cfg_address} !== {1'b1, 3'b010, 16'h40F9}) begin
         n_err++;
         $display("FAIL read_cmd: got cyc=%0d cmd=%b addr=%h, want cyc=1 cmd=010 addr=40f9",
                  cyc, {bus.cfg_write, bus.cfg_read, bus.cfg_init}, bus.cfg_address);
      end
      bus.req_valid       = '0;
      bus.req_rnw         = '0;
      bus.req_addr[47:32] = 16'h1234;
      step();
      n_cmp++;
      if (bus.cfg_address !== 16'h40F9) begin
         n_err++;
         $display("FAIL read_post_grant_hold: got addr=%h, want 40f9", bus.cfg_address);
      end
      bus.cfg_rdata = 8'h7F;
      bus.cfg_done  = 1'b1;
      step();
      bus.cfg_done  = 1'b0;
      n_cmp++;
      if ({bus.req_ack, bus.rsp_rdata, bus.rsp_err} !== {4'b0100, 8'h7F, 1'b0}) begin
         n_err++;
         $display("FAIL read_ack: got ack=%b rdata=%h err=%b, want ack=0100 rdata=7f err=0",
                  bus.req_ack, bus.rsp_rdata, bus.rsp_err);
      end
      step();
   endtask

   task automatic test_stray_done();
      int bad;
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if ({bus.req_ack, bus.init_ack, bus.cfg_write, bus.cfg_read, bus.cfg_init} != 8'h00) bad++;
         step();
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL stray_done: got %0d cycles with activity, want 0", bad); end
   endtask

   task automatic test_round_robin();
      int         cyc;
      int         order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] exp_ack;
      do_reset();
      bus.req_addr  = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
      bus.req_wdata = {8'h33, 8'h22, 8'h11, 8'h00};
      bus.req_rnw   = 4'b0000;
      bus.req_valid = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         exp_ack = 4'b0001 << order[t];
         wait_cmd(cyc);
         n_cmp++;
         if (cyc !== (t == 0 ? 1 : 2)) begin
            n_err++;
            $display("FAIL rr_gap[%0d]: got %0d cycles, want %0d", t, cyc, t == 0 ? 1 : 2);
         end
         n_cmp++;
         if ({bus.cfg_write, bus.cfg_read, bus.cfg_init, bus.cfg_address} !== {3'b100, 16'h4000 + 16'(order[t])}) begin
            n_err++;
            $display("FAIL rr_cmd[%0d]: got cmd=%b addr=%h, want cmd=100 addr=%h", t,
                     {bus.cfg_write, bus.cfg_read, bus.cfg_init}, bus.cfg_address, 16'h4000 + 16'(order[t]));
         end
         step();
         n_cmp++;
         if ({bus.cfg_write, bus.cfg_read, bus.cfg_init} !== 3'b000) begin
            n_err++;
            $display("FAIL rr_single_pulse[%0d]: got cmd=%b, want 000", t, {bus.cfg_write, bus.cfg_read, bus.cfg_init});
         end
         bus.cfg_done = 1'b1;
         step();
         bus.cfg_done = 1'b0;
         n_cmp++;
         if (bus.req_ack !== exp_ack) begin
            n_err++;
            $display("FAIL rr_ack[%0d]: got ack=%b, want %b", t, bus.req_ack, exp_ack);
         end
      end
      bus.req_valid = '0;
      step();
   endtask

   task automatic test_init_priority();
      int cyc;
      bus.init_req  = 1'b1;
      bus.req_valid = 4'b0001;
      wait_cmd(cyc);
      n_cmp++;
      if ({cyc == 1, bus.cfg_write, bus.cfg_read, bus.cfg_init} !== 4'b1001) begin
         n_err++;
         $display("FAIL init_first: got cyc=%0d cmd=%b, want cyc=1 cmd=001", cyc, {bus.cfg_write, bus.cfg_read, bus.cfg_init});
      end
      step();
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      n_cmp++;
      if ({bus.init_ack, bus.req_ack} !== 5'b1_0000) begin
         n_err++;
         $display("FAIL init_ack: got init_ack=%b ack=%b, want init_ack=1 ack=0000", bus.init_ack, bus.req_ack);
      end
      bus.init_req = 1'b0;
      wait_cmd(cyc);
      n_cmp++;
      if ({cyc == 2, bus.cfg_write, bus.cfg_read, bus.cfg_init, bus.cfg_address} !== {1'b1, 3'b100, 16'h4000}) begin
         n_err++;
         $display("FAIL init_then_req0: got cyc=%0d cmd=%b addr=%h, want cyc=2 cmd=100 addr=4000",
                  cyc, {bus.cfg_write, bus.cfg_read, bus.cfg_init}, bus.cfg_address);
      end
      step();
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      n_cmp++;
      if ({bus.init_ack, bus.req_ack} !== 5'b0_0001) begin
         n_err++;
         $display("FAIL init_req0_ack: got init_ack=%b ack=%b, want init_ack=0 ack=0001", bus.init_ack, bus.req_ack);
      end
      bus.req_valid = '0;
      step();
   endtask

   task automatic test_reset_abort();
      int cyc;
      int bad;
      bus.req_valid = 4'b0001;
      wait_cmd(cyc);
      step();
      step();
      resetn = 1'b0;
      #1;
      n_cmp++;
      if ({bus.init_ack, bus.req_ack, bus.cfg_write, bus.cfg_read, bus.cfg_init, bus.cfg_address,
           bus.cfg_wdata, bus.rsp_rdata, bus.rsp_err} !== 41'h0) begin
         n_err++;
         $display("FAIL abort_outputs: got ack=%b cmd=%b addr=%h wdata=%h, want all zero",
                  bus.req_ack, {bus.cfg_write, bus.cfg_read, bus.cfg_init}, bus.cfg_address, bus.cfg_wdata);
      end
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      bad = (bus.req_ack != 4'b0000) ? 1 : 0;
      resetn = 1'b1;
      wait_cmd(cyc);
      n_cmp++;
      if ({bad == 0, cyc == 1, bus.cfg_write, bus.cfg_read, bus.cfg_init, bus.cfg_address} !== {2'b11, 3'b100, 16'h4000}) begin
         n_err++;
         $display("FAIL abort_reissue: got ack_in_reset=%0d cyc=%0d cmd=%b addr=%h, want 0 1 100 4000",
                  bad, cyc, {bus.cfg_write, bus.cfg_read, bus.cfg_init}, bus.cfg_address);
      end
      step();
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      n_cmp++;
      if (bus.req_ack !== 4'b0001) begin n_err++; $display("FAIL abort_ack: got ack=%b, want 0001", bus.req_ack); end
      bus.req_valid = '0;
      step();
   endtask

`ifdef ADAU_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int cyc;
      int n;
      int bad;
      bus.req_addr[63:48] = 16'h4003;
      bus.req_rnw         = 4'b1000;
      bus.cfg_rdata       = 8'h5A;
      bus.req_valid       = 4'b1000;
      wait_cmd(cyc);
      n = 0;
      do begin
         step();
         n++;
      end while (bus.req_ack == 4'b0000 && n < 40);
      n_cmp++;
      if (n !== 17) begin n_err++; $display("FAIL timeout_latency: got %0d cycles, want 17", n); end
      n_cmp++;
      if ({bus.req_ack, bus.rsp_err, bus.rsp_rdata} !== {4'b1000, 1'b1, 8'h00}) begin
         n_err++;
         $display("FAIL timeout_ack: got ack=%b err=%b rdata=%h, want ack=1000 err=1 rdata=00",
                  bus.req_ack, bus.rsp_err, bus.rsp_rdata);
      end
      bus.req_valid = '0;
      step();
      bus.cfg_done = 1'b1;
      step();
      bus.cfg_done = 1'b0;
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         if (bus.req_ack != 4'b0000) bad++;
         step();
      end
      n_cmp++;
      if (bad !== 0) begin n_err++; $display("FAIL timeout_late_done: got %0d extra acks, want 0", bad); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_write();
      test_single_read();
      test_stray_done();
      test_round_robin();
      test_init_priority();
      test_reset_abort();
`ifdef ADAU_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
